// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate feeding the sigmoid ROM index.
// Three stages: operand capture (S1), full-width product (S2), then
// accumulate/bias/rescale/saturate (S3). One out_valid pulse per vector.
module neuron_mac #(
    parameter int numWeight = 4,
    parameter int dataWidth = 16,
    parameter int fracBits  = 8,
    parameter int inWidth   = 10,
    parameter int xFracBits = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic signed [dataWidth-1:0]         in_data,
    input  logic                                weight_we,
    input  logic        [$clog2(numWeight)-1:0] weight_addr,
    input  logic signed [dataWidth-1:0]         weight_din,
    input  logic                                bias_we,
    input  logic signed [dataWidth-1:0]         bias_din,
    output logic                                out_valid,
    output logic signed [inWidth-1:0]           out_x,
    output logic                                out_sat,
    output logic                                busy
);

    localparam int AW    = $clog2(numWeight);
    localparam int PW    = 2 * dataWidth;
    localparam int ACC_W = PW + AW + 1;
    localparam int SH    = 2 * fracBits - xFracBits;

    localparam logic signed [ACC_W-1:0] X_MAX = ACC_W'((2 ** (inWidth - 1)) - 1);
    localparam logic signed [ACC_W-1:0] X_MIN = -X_MAX - ACC_W'(1);

    // Clamp a rescaled sum to the ROM index range; MSB of the result flags clamping.
    function automatic logic [inWidth:0] sat_x(input logic signed [ACC_W-1:0] v);
        if (v > X_MAX) return {1'b1, X_MAX[inWidth-1:0]};
        if (v < X_MIN) return {1'b1, X_MIN[inWidth-1:0]};
        return {1'b0, v[inWidth-1:0]};
    endfunction

    // Coefficient storage: no reset, survives rst_n.
    logic signed [dataWidth-1:0] w_mem [numWeight];
    logic signed [dataWidth-1:0] bias_q;

    // Control state
    logic [AW-1:0] cnt_q, cnt_d;
    logic          in_last;
    logic          vld_p1_q, vld_p2_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    out_valid_q;
    logic signed [inWidth-1:0] out_x_q;
    logic                    out_sat_q;

    // Datapath registers
    logic signed [dataWidth-1:0] data_p1_q, w_p1_q;
    logic                        last_p1_q;
    logic signed [PW-1:0]        prod_p2_q;
    logic                        last_p2_q;

    // S3 combinational terms
    logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_sum, fin_sum, scaled;
    logic        [inWidth:0] sat_res;

    // Input sample counter: wraps after the last index of a vector.
    always_comb begin
        cnt_d   = cnt_q;
        in_last = (cnt_q == AW'(numWeight - 1));
        if (in_valid) cnt_d = in_last ? '0 : cnt_q + AW'(1);
    end

    // Accumulate and final bias/rescale/saturate arithmetic.
    always_comb begin
        prod_ext = ACC_W'(prod_p2_q);
        bias_ext = ACC_W'(bias_q) <<< fracBits;
        acc_sum  = acc_q + prod_ext;
        fin_sum  = acc_sum + bias_ext;
        scaled   = fin_sum >>> SH;
        sat_res  = sat_x(scaled);
    end

    // Weight and bias writes; S1 reads on the same edge see the old value.
    always_ff @(posedge clk) begin
        if (weight_we) w_mem[weight_addr] <= weight_din;
        if (bias_we)   bias_q             <= bias_din;
    end

    // ---- S1 / S2 data capture (valid bits qualify these) ----
    always_ff @(posedge clk) begin
        data_p1_q <= in_data;
        w_p1_q    <= w_mem[cnt_q];
        last_p1_q <= in_last;
        prod_p2_q <= PW'(data_p1_q) * PW'(w_p1_q);
        last_p2_q <= last_p1_q;
    end

    // ---- Control, accumulator and S3 output registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q & last_p2_q;
            if (vld_p2_q) begin
                acc_q <= last_p2_q ? '0 : acc_sum;
                if (last_p2_q) begin
                    out_x_q   <= sat_res[inWidth-1:0];
                    out_sat_q <= sat_res[inWidth];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_sat   = out_sat_q;
    assign busy      = (cnt_q != '0) | vld_p1_q | vld_p2_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: driver pushes expected results computed
// from a plain-arithmetic neuron model; a monitor pops on every out_valid.
module tb_neuron_mac;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               weight_we = 1'b0;
    logic [1:0]         weight_addr = '0;
    logic signed [15:0] weight_din = '0;
    logic               bias_we = 1'b0;
    logic signed [15:0] bias_din = '0;
    logic               out_valid;
    logic signed [9:0]  out_x;
    logic               out_sat;
    logic               busy;

    neuron_mac dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .weight_we(weight_we), .weight_addr(weight_addr), .weight_din(weight_din),
        .bias_we(bias_we), .bias_din(bias_din), .out_valid(out_valid),
        .out_x(out_x), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int     x;
        bit     sat;
        longint cyc;
    } exp_t;
    exp_t sb[$];

    // Reference neuron state
    int     w_m[4];
    int     b_m = 0;
    longint part = 0;
    int     idx = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Real-valued view: sum has 16 fraction bits, index has 5, so divide by 2^11 rounding to -inf.
    function automatic exp_t model_result(input longint s, input longint c);
        exp_t   e;
        longint q;
        q = s / 2048;
        if ((s % 2048) != 0 && s < 0) q = q - 1;
        e.sat = 1'b0;
        if (q > 511)  begin q = 511;  e.sat = 1'b1; end
        if (q < -512) begin q = -512; e.sat = 1'b1; end
        e.x   = int'(q);
        e.cyc = c;
        return e;
    endfunction

    function automatic int rnd16();
        int r;
        logic signed [15:0] t;
        r = int'($urandom);
        t = r[15:0];
        case ($urandom_range(0, 3))
            0: return int'(t);
            1: return int'($urandom_range(0, 600)) - 300;
            2: return ($urandom_range(0, 1) == 0) ? 32767 : -32768;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic write_w(input int a, input int v);
        weight_we = 1'b1; weight_addr = a[1:0]; weight_din = v[15:0];
        w_m[a] = v;
        @(posedge clk); #1;
        weight_we = 1'b0;
    endtask

    task automatic write_b(input int v);
        bias_we = 1'b1; bias_din = v[15:0];
        b_m = v;
        @(posedge clk); #1;
        bias_we = 1'b0;
    endtask

    task automatic set_all_w(input int v);
        for (int i = 0; i < 4; i++) write_w(i, v);
    endtask

    // One input sample, optionally with a simultaneous weight write.
    task automatic sample(input int d, input bit ww, input int wa, input int wd);
        in_valid = 1'b1; in_data = d[15:0];
        if (ww) begin
            weight_we = 1'b1; weight_addr = wa[1:0]; weight_din = wd[15:0];
        end
        part = part + longint'(d) * longint'(w_m[idx]);
        if (ww) w_m[wa] = wd;
        if (idx == 3) begin
            sb.push_back(model_result(part + longint'(b_m) * 256, cyc + 3));
            part = 0;
            idx  = 0;
        end else begin
            idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; weight_we = 1'b0;
    endtask

    task automatic drain();
        idle(6);
        chk("drain_pending", sb.size(), 0);
        chk("busy_idle", busy, 0);
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_x"}, out_x, 0);
        chk({tag, "_out_sat"}, out_sat, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: compare every output pulse against the oldest expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: out_x=%0d with no result expected", out_x);
            end else begin
                e = sb.pop_front();
                chk("out_x", out_x, e.x);
                chk("out_sat", out_sat, e.sat);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        // Nominal vector
        set_all_w(128);
        write_b(64);
        sample(256, 1'b0, 0, 0);
        chk("busy_mid_vector", busy, 1);
        for (int i = 0; i < 3; i++) sample(256, 1'b0, 0, 0);
        drain();

        // Positive saturation
        set_all_w(32767);
        write_b(0);
        for (int i = 0; i < 4; i++) sample(32767, 1'b0, 0, 0);
        drain();

        // Negative saturation
        set_all_w(-32768);
        for (int i = 0; i < 4; i++) sample(32767, 1'b0, 0, 0);
        drain();

        // Truncation toward -inf
        set_all_w(0);
        write_w(0, 1);
        write_b(0);
        sample(-1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) sample(0, 1'b0, 0, 0);
        drain();

        // Back-to-back vectors, second one with a gap
        set_all_w(128);
        write_b(64);
        for (int i = 0; i < 4; i++) sample(256, 1'b0, 0, 0);
        sample(0, 1'b0, 0, 0);
        sample(0, 1'b0, 0, 0);
        idle(1);
        sample(0, 1'b0, 0, 0);
        sample(0, 1'b0, 0, 0);
        drain();

        // Reset mid-vector: partial data discarded, coefficients kept
        sample(256, 1'b0, 0, 0);
        sample(256, 1'b0, 0, 0);
        rst_n = 1'b0;
        part  = 0;
        idx   = 0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) sample(256, 1'b0, 0, 0);
        drain();

        // Randomized vectors with gaps and concurrent weight writes
        for (int v = 0; v < 40; v++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain();
                write_b(rnd16());
            end
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                sample(rnd16(), ($urandom_range(0, 3) == 0),
                       int'($urandom_range(0, 3)), rnd16());
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Per-neuron multiply-accumulate stage sitting directly upstream of the sigmoid lookup ROM in the MLP datapath. Consumes a stream of signed fixed-point activations, multiplies each by a locally stored weight, accumulates over one input vector, adds the bias, then rescales and saturates the sum into the signed `inWidth`-bit index format the sigmoid ROM expects. Emits one result per input vector with a single-cycle valid pulse.

## Interface
- `numWeight`, 4: inputs per vector; also the weight memory depth.
- `dataWidth`, 16: width of activations, weights and bias; signed two's complement.
- `fracBits`, 8: fractional bits of activations, weights and bias.
- `inWidth`, 10: width of `out_x`; must match the sigmoid ROM `inWidth`.
- `xFracBits`, 5: fractional bits of `out_x`; must satisfy `xFracBits <= 2*fracBits`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid this cycle; no backpressure.
- `in_data`  in  dataWidth  signed activation.
- `weight_we`  in  1  weight write strobe.
- `weight_addr`  in  clog2(numWeight)  weight write address.
- `weight_din`  in  dataWidth  signed weight.
- `bias_we`  in  1  bias write strobe.
- `bias_din`  in  dataWidth  signed bias.
- `out_valid`  out  1  one-cycle pulse: `out_x` is new.
- `out_x`  out  inWidth  signed, rescaled, saturated neuron sum; drives the sigmoid ROM `x`.
- `out_sat`  out  1  saturation occurred for the current `out_x`.
- `busy`  out  1  a vector is partially received or results are in flight.

## Operation
- Input counter `cnt` (0..numWeight-1) advances on each `in_valid`. It wraps to 0 after `numWeight-1`; that sample is tagged `last`. Gaps between samples are allowed.
- Stage S1 (registered): `in_data`, `weight[cnt]`, `last` and a valid bit.
- Stage S2 (registered): full-width signed product `in_data*weight` (2*dataWidth bits), `last` and valid.
- Stage S3 (accumulator/output register), on an S2-valid cycle:
  - First product of a vector loads the accumulator; subsequent products add to it.
  - On `last`: `sum = acc + prod + (bias <<< fracBits)`.
  - `out_x = sat_inWidth(sum >>> (2*fracBits - xFracBits))`. The shift is arithmetic, so it truncates toward -inf.
  - `out_sat` is set if clamping occurred; `out_valid` pulses. The accumulator then restarts with the next vector.
- Accumulator width is `2*dataWidth + clog2(numWeight) + 1`, so it never overflows internally.
- Saturation limits are `+(2^(inWidth-1))-1` and `-2^(inWidth-1)`.
- Weight and bias storage:
  - Plain register array, no reset; contents are retained across `rst_n`.
  - A write lands at the clock edge. An S1 read on the same edge captures the pre-write value.
- `out_x` and `out_sat` hold their value between pulses.
- `busy = (cnt != 0) | S1.valid | S2.valid`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `out_valid`=0, `out_x`=0, `out_sat`=0, `busy`=0.
  - `cnt`=0, all pipeline valid bits=0, accumulator=0.
  - Reset mid-vector discards partial data. The first sample after release is index 0.
- Latency: last sample accepted with `in_valid` in cycle T gives `out_valid` high in cycle T+3, for exactly one cycle.
- Throughput: one sample per cycle. Back-to-back vectors with no idle cycle are supported. The first sample of vector N+1 may arrive in cycle T+1, and its result is independent of vector N.
- For the sigmoid ROM's 2-cycle latency, the sigmoid output corresponds to `out_x` from 2 cycles earlier; downstream delays `out_valid` accordingly.
- A weight or bias write in the same cycle as `in_valid` is legal; the ordering follows the read-before-write rule above.

## Test plan
- Nominal vector:
  - Setup: bias=64 (0.25); weights all 128 (0.5).
  - Stimulus: four samples of 256 (1.0) in cycles T..T+3.
  - Required: `out_valid` in T+6, `out_x`=72 (2.25), `out_sat`=0.
- Positive saturation:
  - Setup: weights=32767, bias=0.
  - Stimulus: inputs=32767.
  - Required: `out_x`=511, `out_sat`=1.
- Negative saturation:
  - Setup: weights=-32768.
  - Stimulus: inputs=32767.
  - Required: `out_x`=-512, `out_sat`=1.
- Truncation toward -inf:
  - Setup: weight[0]=1, other weights=0, bias=0.
  - Stimulus: input[0]=-1.
  - Required: `out_x`=-1, `out_sat`=0.
- Back-to-back with gaps:
  - Stimulus: vector A (nominal) in 4 consecutive cycles, then vector B (inputs 0) with one idle cycle between its 2nd and 3rd samples.
  - Required: A gives 72; B gives 8 (bias only, 0.25×32); `busy` low once B's result is out.
- Reset mid-vector:
  - Stimulus: two nominal samples, then `rst_n` low for 1 cycle, then a full nominal vector.
  - Required: all outputs 0 during reset; exactly one `out_valid`, with `out_x`=72; weights and bias unchanged.
